// File: rtl/chip_tester_pkg.sv
// Shared types and helpers for the parametrised 2-input gate chip tester.
// CHIP_TESTER_SYNC_EN selects the synchronizer latency absorbed per vector.
package chip_tester_pkg;

  typedef enum logic [2:0] {
    ST_HALTED = 3'd0,
    ST_SET    = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    G_NAND = 3'd0,
    G_NOR  = 3'd1,
    G_AND  = 3'd2,
    G_OR   = 3'd3,
    G_XOR  = 3'd4,
    G_XNOR = 3'd5,
    G_INV6 = 3'd6,
    G_INV7 = 3'd7
  } gate_e;

`ifdef CHIP_TESTER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  function automatic logic gate_eval(gate_e g, logic a, logic b);
    case (g)
      G_NAND:  return ~(a & b);
      G_NOR:   return ~(a | b);
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_XOR:   return a ^ b;
      G_XNOR:  return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic gate_valid(logic [2:0] sel);
    return sel <= 3'd5;
  endfunction

endpackage

// File: rtl/chip_gate_tester_if.sv
// Control, status and chip-pin bundle between the tester and its environment.
// master = the tester itself, slave = pin wrapper / display side.
interface chip_gate_tester_if #(
  parameter int NUM_GATES = 4
);
  logic                 Run;
  logic [2:0]           Gate_Sel;
  logic                 DISP_RSLT;
  logic [NUM_GATES-1:0] Chip_Y;
  logic [NUM_GATES-1:0] Chip_A;
  logic [NUM_GATES-1:0] Chip_B;
  logic                 Done;
  logic                 RSLT;
  logic                 Err;
  logic [NUM_GATES-1:0] Fail_Mask;
  logic [1:0]           Vector_o;
  logic [2:0]           State_o;

  modport master (
    input  Run, Gate_Sel, DISP_RSLT, Chip_Y,
    output Chip_A, Chip_B, Done, RSLT, Err, Fail_Mask, Vector_o, State_o
  );

  modport slave (
    output Run, Gate_Sel, DISP_RSLT, Chip_Y,
    input  Chip_A, Chip_B, Done, RSLT, Err, Fail_Mask, Vector_o, State_o
  );
endinterface

// File: rtl/chip_input_sync.sv
// Two-flop synchronizer for the chip output pins; only built when
// CHIP_TESTER_SYNC_EN is defined.
`ifdef CHIP_TESTER_SYNC_EN
module chip_input_sync #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule
`endif

// File: rtl/chip_gate_tester.sv
// Exhaustive tester for chips of NUM_GATES identical 2-input gates.
// CHIP_TESTER_SYNC_EN inserts a 2-flop synchronizer on Chip_Y and stretches each vector.
module chip_gate_tester
  import chip_tester_pkg::*;
#(
  parameter int NUM_GATES     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                Clk,
  input logic                Reset,
  chip_gate_tester_if.master bus
);
  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 3);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES + SYNC_LAT);

  state_e               state_q, state_d;
  gate_e                sel_q, sel_d;
  logic [1:0]           vec_q, vec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rslt_q, rslt_d;
  logic                 err_q, err_d;
  logic [NUM_GATES-1:0] mask_q, mask_d;
  logic [NUM_GATES-1:0] y_cmp;
  logic [NUM_GATES-1:0] y_exp;
  logic                 driving;

`ifdef CHIP_TESTER_SYNC_EN
  chip_input_sync #(.WIDTH(NUM_GATES)) u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d_i   (bus.Chip_Y),
    .q_o   (y_cmp)
  );
`else
  assign y_cmp = bus.Chip_Y;
`endif

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_HALTED;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_q  <= G_NAND;
      vec_q  <= '0;
      cnt_q  <= '0;
      rslt_q <= 1'b0;
      err_q  <= 1'b0;
      mask_q <= '0;
    end else begin
      sel_q  <= sel_d;
      vec_q  <= vec_d;
      cnt_q  <= cnt_d;
      rslt_q <= rslt_d;
      err_q  <= err_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value is defaulted first so no branch can infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    rslt_d  = rslt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    y_exp   = {NUM_GATES{gate_eval(sel_q, vec_q[1], vec_q[0])}};

    case (state_q)
      ST_HALTED: begin
        if (bus.Run) begin
          sel_d = gate_e'(bus.Gate_Sel);
          if (gate_valid(bus.Gate_Sel)) begin
            state_d = ST_SET;
          end else begin
            state_d = ST_DONE;
            rslt_d  = 1'b0;
            err_d   = 1'b1;
            mask_d  = '0;
          end
        end
      end
      ST_SET: begin
        vec_d   = '0;
        rslt_d  = 1'b1;
        mask_d  = '0;
        err_d   = 1'b0;
        cnt_d   = CNT_LOAD;
        state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_SAMPLE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      ST_SAMPLE: begin
        // Any disagreeing gate is flagged; flags only accumulate within a test.
        mask_d = mask_q | (y_cmp ^ y_exp);
        if (y_cmp != y_exp) rslt_d = 1'b0;
        if (vec_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = CNT_LOAD;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        if (bus.DISP_RSLT) state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  assign driving       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign bus.Chip_A    = driving ? {NUM_GATES{vec_q[1]}} : '0;
  assign bus.Chip_B    = driving ? {NUM_GATES{vec_q[0]}} : '0;
  assign bus.Done      = (state_q == ST_DONE);
  assign bus.RSLT      = rslt_q;
  assign bus.Err       = err_q;
  assign bus.Fail_Mask = mask_q;
  assign bus.Vector_o  = vec_q;
  assign bus.State_o   = state_q;

endmodule

// File: tb/tb_chip_gate_tester.sv
// Self-checking bench for chip_gate_tester: a truth-table chip model with
// injectable faults, directed scenarios and randomized fault campaigns.
module tb_chip_gate_tester;
`ifdef CHIP_TESTER_SYNC_EN
  localparam int NG   = 6;
  localparam int SYNC = 2;
`else
  localparam int NG   = 4;
  localparam int SYNC = 0;
`endif
  localparam int SETTLE     = 2;
  localparam int PER_VEC    = SETTLE + 1 + SYNC;
  localparam int TEST_EDGES = 1 + 4 * PER_VEC;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  chip_gate_tester_if #(.NUM_GATES(NG)) bus ();

  chip_gate_tester #(.NUM_GATES(NG), .SETTLE_CYCLES(SETTLE)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks;
  int errors;

  // Truth table per function: bit i is the output for vector i = {a,b}.
  function automatic logic [3:0] tt(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'b0111;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b1000;
      3'd3:    return 4'b1110;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  // Chip model: each gate has its own (possibly faulty) table, optional output delay.
  logic [3:0]    chip_tab [NG];
  int            chip_delay;
  logic [NG-1:0] y_now, y_d1, y_d2;

  always_comb begin
    y_now = '0;
    for (int g = 0; g < NG; g++) y_now[g] = chip_tab[g][{bus.Chip_A[g], bus.Chip_B[g]}];
  end

  always @(posedge Clk) begin
    y_d1 <= y_now;
    y_d2 <= y_d1;
  end

  assign bus.Chip_Y = (chip_delay == 0) ? y_now : y_d2;

  logic          last_rslt;
  logic [NG-1:0] last_mask;
  logic          last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ideal(input logic [2:0] sel);
    for (int g = 0; g < NG; g++) chip_tab[g] = tt(sel);
  endtask

  task automatic check_idle_zero(input string name);
    check({name, " state"}, 32'(bus.State_o), 0);
    check({name, " done"},  32'(bus.Done), 0);
    check({name, " rslt"},  32'(bus.RSLT), 0);
    check({name, " err"},   32'(bus.Err), 0);
    check({name, " mask"},  32'(bus.Fail_Mask), 0);
    check({name, " vec"},   32'(bus.Vector_o), 0);
    check({name, " a"},     32'(bus.Chip_A), 0);
    check({name, " b"},     32'(bus.Chip_B), 0);
  endtask

  task automatic run_test(input logic [2:0] sel, input string name);
    logic [NG-1:0] exp_mask;
    logic [1:0]    v;
    bit            valid;
    bit            seen;
    int            n;
    int            idx;
    valid    = (sel <= 3'd5);
    exp_mask = '0;
    if (valid)
      for (int g = 0; g < NG; g++) exp_mask[g] = (chip_tab[g] != tt(sel));

    @(negedge Clk);
    bus.Run      = 1'b1;
    bus.Gate_Sel = sel;
    n    = 0;
    idx  = 0;
    seen = 1'b0;
    while (!seen && n < 4 * TEST_EDGES) begin
      @(posedge Clk);
      n++;
      #1;
      bus.Run      = 1'b0;
      bus.Gate_Sel = 3'($urandom);
      @(negedge Clk);
      if (bus.Done) begin
        seen = 1'b1;
      end else begin
        if (idx == 0) begin
          check($sformatf("%s set_a", name), 32'(bus.Chip_A), 0);
          check($sformatf("%s set_b", name), 32'(bus.Chip_B), 0);
        end else begin
          v = 2'((idx - 1) / PER_VEC);
          check($sformatf("%s a[%0d]", name, idx), 32'(bus.Chip_A), 32'({NG{v[1]}}));
          check($sformatf("%s b[%0d]", name, idx), 32'(bus.Chip_B), 32'({NG{v[0]}}));
          check($sformatf("%s vec[%0d]", name, idx), 32'(bus.Vector_o), 32'(v));
        end
        if (idx == 1) begin
          check({name, " cleared_rslt"}, 32'(bus.RSLT), 1);
          check({name, " cleared_mask"}, 32'(bus.Fail_Mask), 0);
          check({name, " cleared_err"},  32'(bus.Err), 0);
        end
        idx++;
      end
    end

    last_rslt = valid && (exp_mask == '0);
    last_mask = exp_mask;
    last_err  = !valid;
    check({name, " done_edges"}, 32'(n), valid ? 32'(1 + TEST_EDGES) : 32'd1);
    check({name, " done"},  32'(bus.Done), 1);
    check({name, " state"}, 32'(bus.State_o), 4);
    check({name, " rslt"},  32'(bus.RSLT), 32'(last_rslt));
    check({name, " err"},   32'(bus.Err), 32'(last_err));
    check({name, " mask"},  32'(bus.Fail_Mask), 32'(last_mask));
    check({name, " a_idle"}, 32'(bus.Chip_A), 0);
    check({name, " b_idle"}, 32'(bus.Chip_B), 0);
  endtask

  // Acknowledge the result (optionally with a simultaneous Run) and confirm it is held.
  task automatic ack(input string name, input logic run_too);
    @(negedge Clk);
    bus.DISP_RSLT = 1'b1;
    bus.Run       = run_too;
    bus.Gate_Sel  = 3'd0;
    @(posedge Clk);
    #1;
    bus.DISP_RSLT = 1'b0;
    bus.Run       = 1'b0;
    @(negedge Clk);
    check({name, " ack_state"}, 32'(bus.State_o), 0);
    check({name, " ack_done"},  32'(bus.Done), 0);
    check({name, " ack_rslt"},  32'(bus.RSLT), 32'(last_rslt));
    check({name, " ack_mask"},  32'(bus.Fail_Mask), 32'(last_mask));
    check({name, " ack_err"},   32'(bus.Err), 32'(last_err));
    @(negedge Clk);
    check({name, " still_halted"}, 32'(bus.State_o), 0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    chip_delay    = 0;
    Reset         = 1'b1;
    bus.Run       = 1'b0;
    bus.Gate_Sel  = 3'd0;
    bus.DISP_RSLT = 1'b0;
    set_ideal(3'd0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle_zero("reset");
    Reset = 1'b0;

    // Ideal NAND chip, then hold the result for a few cycles before acknowledging.
    set_ideal(3'd0);
    run_test(3'd0, "nand_ideal");
    repeat (2) @(negedge Clk);
    check("nand_hold_done", 32'(bus.Done), 1);
    check("nand_hold_rslt", 32'(bus.RSLT), 1);
    ack("nand_ideal", 1'b1);

    // XOR chip with gate 2 stuck at 0.
    set_ideal(3'd4);
    chip_tab[2] = 4'b0000;
    run_test(3'd4, "xor_stuck2");
    check("xor_stuck2 mask_const", 32'(bus.Fail_Mask), 32'd4);
    ack("xor_stuck2", 1'b0);

    // A following clean run must clear the previous failure in Set.
    set_ideal(3'd2);
    run_test(3'd2, "and_after_fail");
    ack("and_after_fail", 1'b0);

    // Invalid selections finish immediately with Err.
    run_test(3'd7, "inv7");
    ack("inv7", 1'b0);
    run_test(3'd6, "inv6");
    ack("inv6", 1'b1);

    // Reset during vector 2 of a NOR test.
    set_ideal(3'd1);
    @(negedge Clk);
    bus.Run      = 1'b1;
    bus.Gate_Sel = 3'd1;
    @(posedge Clk);
    #1 bus.Run = 1'b0;
    repeat (1 + 2 * PER_VEC) @(posedge Clk);
    @(negedge Clk);
    check("nor_mid vec_before_reset", 32'(bus.Vector_o), 2);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check_idle_zero("nor_mid_reset");
    @(negedge Clk);
    Reset = 1'b0;
    run_test(3'd1, "nor_after_reset");
    ack("nor_after_reset", 1'b0);

    // Random functions with random per-gate faults.
    for (int t = 0; t < 12; t++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 5));
      for (int g = 0; g < NG; g++) begin
        case ($urandom_range(0, 3))
          2:       chip_tab[g] = {4{1'($urandom)}};
          3:       chip_tab[g] = tt(3'($urandom_range(0, 5)));
          default: chip_tab[g] = tt(sel);
        endcase
      end
      run_test(sel, $sformatf("rand%0d", t));
      ack($sformatf("rand%0d", t), 1'($urandom));
    end

`ifdef CHIP_TESTER_SYNC_EN
    // Slow chip: outputs lag the pins by two cycles, absorbed by the synchronizer budget.
    set_ideal(3'd3);
    chip_delay = 2;
    run_test(3'd3, "or_sync_delay");
    ack("or_sync_delay", 1'b0);
    chip_delay = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip_gate_tester.md
# chip_gate_tester

Parametrised successor to the team's fixed quad-NAND checker. It exhaustively tests any 74xx-style chip built from NUM_GATES identical 2-input gates, with the gate function selected at run time. It drives all four A/B vectors to every gate in parallel, waits a programmable settle time, compares each gate output against the expected value, and reports a pass/fail flag plus a per-gate failure mask. It sits between the board pin wrapper, which maps ports to physical pins, and the result display logic.

## Interface
Parameters:
- NUM_GATES, 4: number of gates on the chip under test (1..8).
- SETTLE_CYCLES, 2: Clk cycles each vector is driven before sampling (>=1).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Run  in  1  start request, sampled only in Halted.
- Gate_Sel  in  3  gate function: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6/7 invalid.
- DISP_RSLT  in  1  result acknowledged; releases Done_s.
- Chip_Y  in  NUM_GATES  gate outputs read from the chip.
- Chip_A  out  NUM_GATES  A input driven to every gate.
- Chip_B  out  NUM_GATES  B input driven to every gate.
- Done  out  1  high while in Done_s.
- RSLT  out  1  1 = all gates passed all vectors.
- Err  out  1  invalid Gate_Sel latched at start.
- Fail_Mask  out  NUM_GATES  bit g set = gate g mismatched on at least one vector.
- Vector_o  out  2  current vector {A,B}, for debug.
- State_o  out  3  current state encoding, for debug.

## Operation
- States: Halted=0, Set=1, Drive=2, Sample=3, Done_s=4.
- Halted:
  - Run=1 latches Gate_Sel into sel_q.
  - If sel_q is valid, go to Set. If invalid, go directly to Done_s with RSLT=0, Err=1, Fail_Mask=0.
- Set (1 cycle): clear vector to 0, RSLT to 1, Fail_Mask to 0, Err to 0, and load the settle counter. Next state is Drive.
- Drive: Chip_A = {NUM_GATES{vector[1]}} and Chip_B = {NUM_GATES{vector[0]}}. The counter decrements each cycle; when it reaches 1, go to Sample.
- Sample (1 cycle):
  - Chip_A/B stay driven.
  - Expected value Y = gate_eval(sel_q, vector[1], vector[0]).
  - For each g, if Chip_Y[g] != Y then Fail_Mask[g] <= 1 and RSLT <= 0.
  - If vector == 3, go to Done_s. Otherwise increment the vector, reload the counter, and go to Drive.
- Done_s: Done=1. RSLT, Fail_Mask and Err hold. DISP_RSLT=1 moves to Halted.
- Results persist in Halted until the next Set.
- Chip_A/B are 0 in every state other than Drive and Sample.
- Run is ignored outside Halted. Gate_Sel changes after start are ignored.
- Vector is 2 bits, counts 0..3, and never wraps within a test.

## Timing
- Reset values: state Halted; Chip_A, Chip_B, Done, RSLT, Err, Fail_Mask, Vector_o all 0; State_o 0.
- Reset mid-test: next cycle is Halted with all of the above values. No partial result is kept.
- Latency: Set is entered on the edge after Run is sampled. Done_s is entered 1 + 4×(SETTLE_CYCLES+1+SYNC_LAT) edges after Set is entered.
  - SYNC_LAT is 0 when CHIP_TESTER_SYNC_EN is undefined, 2 when it is defined.
  - With defaults and no sync: 13 edges.
- Comparison uses Chip_Y registered at the Sample edge. The Fail_Mask and RSLT updates are visible one cycle after Sample.
- Simultaneous DISP_RSLT and Run in Done_s: go to Halted. Run is not honoured until it is sampled in Halted.
- Invalid Gate_Sel: Done rises 1 edge after Run is sampled.

## Configuration
- CHIP_TESTER_SYNC_EN defined:
  - Chip_Y passes through a 2-flop synchronizer before comparison.
  - The settle counter is loaded with SETTLE_CYCLES+2 so that synchronizer latency is absorbed.
  - Per-vector time grows by 2 cycles.
- Undefined: Chip_Y is compared directly. The counter is loaded with SETTLE_CYCLES.

## Structure
- Package chip_tester_pkg:
  - state_e enum (3-bit).
  - gate_e enum (3-bit, encodings as listed under Interface).
  - Function gate_eval(gate_e, logic a, logic b) returning the expected output; invalid codes return 0.
  - Constant SYNC_LAT.
- Sub-module chip_input_sync (width NUM_GATES, 2-flop), instantiated only under CHIP_TESTER_SYNC_EN.
- Settle counter width: $clog2(SETTLE_CYCLES+3).

## Test plan
- NAND, NUM_GATES=4, ideal chip model. Run pulse -> Done after 13 edges, RSLT=1, Fail_Mask=4'b0000, Err=0.
- XOR, gate 2 stuck-at-0 -> RSLT=0, Fail_Mask=4'b0100. Chip_A/B sequence is 00, 01, 10, 11, with each vector held for 3 cycles.
- Gate_Sel=7 with Run -> Done_s after 1 edge, Err=1, RSLT=0, Chip_A/B never leave 0.
- Reset asserted during vector 2 of a NOR test -> next cycle State_o=0, all outputs 0. A subsequent Run gives a full, clean test.
- DISP_RSLT in Done_s -> Halted with RSLT/Fail_Mask held. The next Run clears them in Set.
- CHIP_TESTER_SYNC_EN defined, NUM_GATES=6, OR, chip output delayed 2 cycles -> RSLT=1 and Done after 1+4×5=21 edges.
